// File: rtl/adder_arb.sv
// Round-robin arbiter/sequencer sharing one 4-bit ripple adder between two requesters.
// SUB runs two passes (A + ~B, then +1) because the shared adder has no carry-in.
module adder_arb #(
  parameter int PASS_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       op0,
  input  logic       op1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [3:0] result,
  output logic       vflag,
  output logic       busy,
  output logic [3:0] add_a,
  output logic [3:0] add_b,
  input  logic [3:0] add_sum,
  input  logic       add_ovf
);

  typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(PASS_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] opa;
  logic [3:0] opb;
  logic [3:0] tmp;
  logic [3:0] cnt;
  logic       op;
  logic       owner;
  logic       last;
  logic       accept;
  logic       pick;
  logic       pass_end;
  logic       sub_v;

  // On a tie the requester that was not granted last time wins.
  assign accept   = req0 | req1;
  assign pick     = (req0 & req1) ? ~last : req1;
  assign pass_end = (cnt == CNT_LAST);
  assign sub_v    = (opa[3] ^ opb[3]) & (add_sum[3] ^ opa[3]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    add_a     = 4'b0000;
    add_b     = 4'b0000;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) state_nxt = PASS1;
      end
      PASS1: begin
        add_a = opa;
        add_b = op ? ~opb : opb;
        if (cnt == 4'd0) begin
          gnt0 = ~owner;
          gnt1 = owner;
        end
        if (pass_end) state_nxt = op ? PASS2 : DONE;
      end
      PASS2: begin
        add_a = tmp;
        add_b = 4'b0001;
        if (pass_end) state_nxt = DONE;
      end
      DONE: begin
        done0     = ~owner;
        done1     = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // result/vflag load on the edge entering DONE so they are valid during the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= 4'b0000;
      opb    <= 4'b0000;
      tmp    <= 4'b0000;
      cnt    <= 4'b0000;
      op     <= 1'b0;
      owner  <= 1'b0;
      last   <= 1'b1;
      result <= 4'b0000;
      vflag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            opa   <= pick ? a1 : a0;
            opb   <= pick ? b1 : b0;
            op    <= pick ? op1 : op0;
            owner <= pick;
            last  <= pick;
            cnt   <= 4'b0000;
          end
        end
        PASS1: begin
          if (pass_end) begin
            tmp <= add_sum;
            cnt <= 4'b0000;
            if (!op) begin
              result <= add_sum;
              vflag  <= add_ovf;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        PASS2: begin
          if (pass_end) begin
            tmp    <= add_sum;
            result <= add_sum;
            vflag  <= sub_v;
            cnt    <= 4'b0000;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arb.sv
// Directed bench for adder_arb: one instance with a modelled adder (PASS_CYCLES=1),
// one with a bench-driven SUM that is only correct on each pass's last cycle (PASS_CYCLES=3).
module tb_adder_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, op0, op1;
  logic [3:0] a0, b0, a1, b1;

  logic       gnt0, gnt1, done0, done1, vflag, busy, add_ovf;
  logic [3:0] result, add_a, add_b, add_sum;

  logic       gnt0_3, gnt1_3, done0_3, done1_3, vflag_3, busy_3, add_ovf_3;
  logic [3:0] result_3, add_a_3, add_b_3, add_sum_3;

  logic [4:0] flags, flags_3;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  assign add_sum = add_a + add_b;
  assign add_ovf = (add_a[3] == add_b[3]) && (add_sum[3] != add_a[3]);
  assign flags   = {busy, gnt1, gnt0, done1, done0};
  assign flags_3 = {busy_3, gnt1_3, gnt0_3, done1_3, done0_3};

  adder_arb #(.PASS_CYCLES(1)) u_arb1 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .result(result), .vflag(vflag), .busy(busy),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_ovf(add_ovf)
  );

  adder_arb #(.PASS_CYCLES(3)) u_arb3 (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0_3), .gnt1(gnt1_3),
    .done0(done0_3), .done1(done1_3), .result(result_3), .vflag(vflag_3), .busy(busy_3),
    .add_a(add_a_3), .add_b(add_b_3), .add_sum(add_sum_3), .add_ovf(add_ovf_3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic r0, input logic r1, input logic o0, input logic o1,
                                input logic [3:0] x0, input logic [3:0] y0,
                                input logic [3:0] x1, input logic [3:0] y1);
    req0 = r0; req1 = r1; op0 = o0; op1 = o1;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
  endtask

  task automatic clear_stimulus();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  // Single-requester operation on the PASS_CYCLES=1 instance, starting in an IDLE cycle.
  task automatic run_op1(input logic who, input logic op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] exp_r, input logic exp_v, input string tag);
    logic [3:0] b_drv;
    logic [3:0] tmp_e;
    logic [4:0] gnt_f;
    logic [4:0] done_f;
    b_drv  = op ? ~b : b;
    tmp_e  = a + b_drv;
    gnt_f  = who ? 5'b11000 : 5'b10100;
    done_f = who ? 5'b10010 : 5'b10001;
    apply_stimulus(!who, who, op, op, a, b, a, b);
    tick();
    check_output({tag, "_gnt"}, 8'(flags), 8'(gnt_f));
    check_output({tag, "_pass1"}, {add_a, add_b}, {a, b_drv});
    clear_stimulus();
    if (op) begin
      tick();
      check_output({tag, "_p2flags"}, 8'(flags), 8'(5'b10000));
      check_output({tag, "_pass2"}, {add_a, add_b}, {tmp_e, 4'b0001});
    end
    tick();
    check_output({tag, "_done"}, 8'(flags), 8'(done_f));
    check_output({tag, "_res"}, 8'({result, vflag}), 8'({exp_r, exp_v}));
    tick();
    check_output({tag, "_idle"}, 8'(flags), 8'(5'b00000));
    check_output({tag, "_hold"}, 8'({result, vflag, add_a}), 8'({exp_r, exp_v, 4'd0}) | 8'd0);
  endtask

  initial begin
    logic [4:0] rr_exp [7];
    rr_exp = '{5'b10100, 5'b10001, 5'b00000, 5'b11000, 5'b10010, 5'b00000, 5'b10100};
    rst_n     = 1'b0;
    add_sum_3 = 4'd0;
    add_ovf_3 = 1'b0;
    clear_stimulus();

    #12;
    check_output("reset_flags", 8'(flags), 8'd0);
    check_output("reset_res", 8'({result, vflag}), 8'd0);
    check_output("reset_add", {add_a, add_b}, 8'd0);
    check_output("reset_flags3", 8'(flags_3), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op1(1'b0, 1'b0, 4'd3,  4'd4, 4'd7,     1'b0, "add_3p4");
    run_op1(1'b1, 1'b0, 4'd7,  4'd1, 4'b1000,  1'b1, "add_7p1");
    run_op1(1'b1, 1'b0, 4'hF,  4'd1, 4'd0,     1'b0, "add_fp1");
    run_op1(1'b0, 1'b1, 4'd2,  4'd5, 4'b1101,  1'b0, "sub_2m5");
    run_op1(1'b0, 1'b1, 4'd8,  4'd1, 4'b0111,  1'b1, "sub_8m1");
    run_op1(1'b1, 1'b1, 4'd0,  4'd0, 4'd0,     1'b0, "sub_0m0");

    // Both requests held from reset: grants alternate starting with req0.
    rst_n = 1'b0;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 4'd2, 4'd2);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_output($sformatf("rr_c%0d", i + 1), 8'(flags), 8'(rr_exp[i]));
      if (i == 1) check_output("rr_res0", 8'(result), 8'd2);
      if (i == 4) check_output("rr_res1", 8'(result), 8'd4);
    end

    // Lone req1 keeps winning even after it was the last grantee.
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd3, 4'd3);
    tick();
    check_output("lone_done0", 8'(flags), 8'(5'b10001));
    tick();
    check_output("lone_idle", 8'(flags), 8'd0);
    tick();
    check_output("lone_gnt1a", 8'(flags), 8'(5'b11000));
    tick();
    check_output("lone_done1a", 8'({flags, 3'b000}), 8'({5'b10010, 3'b000}));
    check_output("lone_res", 8'(result), 8'd6);
    tick();
    tick();
    check_output("lone_gnt1b", 8'(flags), 8'(5'b11000));
    clear_stimulus();
    tick();
    tick();

    // Reset during PASS2 of a SUB drops everything without a done pulse.
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd5, 4'd0, 4'd0);
    tick();
    check_output("mid_gnt", 8'(flags), 8'(5'b10100));
    clear_stimulus();
    tick();
    check_output("mid_pass2", {add_a, add_b}, {4'b1100, 4'b0001});
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_flags", 8'(flags), 8'd0);
    check_output("mid_rst_add", {add_a, add_b}, 8'd0);
    check_output("mid_rst_res", 8'({result, vflag}), 8'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_output("mid_nodone_a", 8'(flags), 8'd0);
    tick();
    check_output("mid_nodone_b", 8'(flags), 8'd0);
    run_op1(1'b0, 1'b1, 4'd2, 4'd5, 4'b1101, 1'b0, "sub_rereq");

    // PASS_CYCLES=3 instance: SUM is garbage except on the last cycle of each pass.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    add_sum_3 = 4'hF;
    add_ovf_3 = 1'b0;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd6, 4'd0, 4'd0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_output($sformatf("p3add_flags_c%0d", i), 8'(flags_3),
                   (i == 1) ? 8'(5'b10100) : 8'(5'b10000));
      check_output($sformatf("p3add_ops_c%0d", i), {add_a_3, add_b_3}, {4'd5, 4'd6});
      if (i == 1) clear_stimulus();
      if (i == 3) begin
        add_sum_3 = 4'b1011;
        add_ovf_3 = 1'b1;
      end
    end
    tick();
    check_output("p3add_done", 8'(flags_3), 8'(5'b10001));
    check_output("p3add_res", 8'({result_3, vflag_3}), 8'({4'b1011, 1'b1}));
    add_sum_3 = 4'h7;
    add_ovf_3 = 1'b1;
    tick();
    check_output("p3add_idle", 8'(flags_3), 8'd0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd0, 4'd3, 4'd6);
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_output($sformatf("p3sub_flags_c%0d", i), 8'(flags_3),
                   (i == 1) ? 8'(5'b11000) : 8'(5'b10000));
      check_output($sformatf("p3sub_ops_c%0d", i), {add_a_3, add_b_3},
                   (i <= 3) ? {4'd3, 4'b1001} : {4'b1100, 4'b0001});
      if (i == 1) clear_stimulus();
      if (i == 3) add_sum_3 = 4'b1100;
      if (i == 4) add_sum_3 = 4'h3;
      if (i == 6) add_sum_3 = 4'b1101;
    end
    tick();
    check_output("p3sub_done", 8'(flags_3), 8'(5'b10010));
    check_output("p3sub_res", 8'({result_3, vflag_3}), 8'({4'b1101, 1'b0}));
    tick();
    check_output("p3sub_idle", 8'(flags_3), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
